pong_msg_receiver: RTL and testbench
====================================

Name: pong_msg_receiver

Overview:
- UART-side message decoder for inter-board Pong link; counterpart to the message transmitter on the peer board.
- Deserialises 8N1 bytes from UART_RXD, frames them into typed messages (ball, miss, new game, new-game ack) and validates them.
- Presents decoded fields to the game state logic through a hold-until-acked handshake.

Parameters:
- CLKS_PER_BIT, 434: CLOCK_50 cycles per UART bit (115200 baud).
- TIMEOUT_BITS, 40: mid-frame idle limit, in bit times, before the parser abandons the frame.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- UART_RXD  in  1  raw serial input, asynchronous, idle high.
- message_acked  in  1  consumer has taken the held message.
- new_message_received  out  1  held message valid.
- ball_message_rx, miss_message_rx, new_game_message_rx, new_game_ack_message_rx  out  1 each  one-hot message type.
- ball_y_rx  out  9  ball row.
- velocity_x_rx, velocity_y_rx  out  4 each  velocity magnitudes.
- sign_y_rx  out  1  sign of vertical velocity.
- my_score_rx, your_score_rx  out  5 each  scores from the receiving side's view.
- you_should_serve_rx  out  1  this side serves next.
- you_serve_first_rx  out  1  this side serves first.
- frame_error  out  1  one-cycle pulse on a dropped frame: bad stop bit, bad checksum or timeout.
- overrun  out  1  one-cycle pulse when a valid frame is discarded because the previous message is unacked.

Behaviour:
- Reset: all outputs 0, byte receiver idle, parser in HUNT, hold register empty.
- Sync: UART_RXD passes through 2 flops, then feeds the byte receiver.
- Byte receiver states: IDLE, START, DATA, STOP.
  - IDLE -> START on a falling edge.
  - Start bit re-checked at CLKS_PER_BIT/2. If high, it is a glitch: return to IDLE with no error.
  - 8 data bits sampled at bit centres, LSB first.
  - Stop bit sampled high: byte_valid pulses for 1 cycle. Stop bit low: byte dropped, frame_error pulses, parser forced to HUNT.
- Frame format: header, payload, checksum. Checksum is the XOR of the header and all payload bytes.
  - 0xA1 ball, 3 payload bytes: b1 = ball_y[7:0]; b2 = {vx[3:0], vy[3:0]}; b3 = {6'b0, sign_y, ball_y[8]}.
  - 0xA2 miss, 2 payload bytes: b1 = {3'b0, sender_my_score}; b2 = {2'b0, you_should_serve, sender_your_score}.
  - 0xA3 new game, 1 payload byte: b1 = {7'b0, you_serve_first}.
  - 0xA4 ack, 0 payload bytes.
  - Unused payload bits are ignored.
- Parser states: HUNT, PAYLOAD, CHECK.
  - HUNT: any byte that is not a valid header is silently discarded.
  - On a valid header: latch the type, load the payload count, go to PAYLOAD. For 0xA4, go straight to CHECK.
  - PAYLOAD: bytes are stored in order into a 3-byte shadow buffer.
  - CHECK: the next byte is compared to the running XOR. On mismatch, frame_error pulses and the parser returns to HUNT.
- Score swap: my_score_rx = sender_your_score; your_score_rx = sender_my_score.
- Commit: a valid checksum byte commits the frame.
  - If the hold register is empty, decoded fields and the one-hot type load, and new_message_received rises the cycle after the byte_valid of the checksum byte.
  - If the hold register is full, the frame is discarded and overrun pulses. The held message is unchanged.
- Handshake:
  - Outputs stay stable while new_message_received = 1.
  - message_acked sampled high with new_message_received = 1 clears new_message_received and the type flags next cycle. Field outputs keep their last values.
  - message_acked while empty is ignored.
  - A commit in the same cycle as the ack of the held message is accepted; there is no overrun.
- Timeout: in PAYLOAD or CHECK, a counter reloads on every byte_valid. If TIMEOUT_BITS*CLKS_PER_BIT cycles pass with no byte, frame_error pulses and the parser goes to HUNT.
- Reset mid-frame or mid-hold: immediate return to the reset state. The partial frame and the held message are lost.

Optional Feature:
- Macro: MSG_CHECKSUM_EN.
- Defined: checksum byte expected and verified as above.
- Undefined: no CHECK state and no checksum byte. The frame commits on the last payload byte. 0xA4 commits on the header byte. The checksum-mismatch error source is absent.

Test Plan:
- Ball frame: bytes A1 2C 32 03 BC -> new_message_received=1, ball_message_rx=1, ball_y_rx=300, velocity_x_rx=3, velocity_y_rx=2, sign_y_rx=1. Held 100 cycles until message_acked; cleared next cycle.
- Miss frame: A2 03 25 84 -> my_score_rx=5, your_score_rx=3, you_should_serve_rx=1, miss_message_rx=1. Bytes 00 55 sent before the header are ignored.
- New game A3 01 A2, acked, then ack frame A4 A4 -> you_serve_first_rx=1 first, then new_game_ack_message_rx=1.
- Errors:
  - Checksum A3 01 00 -> frame_error pulse, no message.
  - Stop bit forced low on a payload byte -> frame_error, parser in HUNT; the following good frame is accepted.
- Overrun: two ball frames back-to-back with no ack -> first frame held, overrun pulses once, fields unchanged. Ack, then a third frame -> accepted.
- Timeout and reset:
  - A1 2C then idle for 41 bit times -> frame_error; the next good frame decodes correctly.
  - reset asserted during byte 2 -> all outputs 0 immediately.

Source files
------------

// File: rtl/pong_msg_receiver.sv
// Pong link receiver: 8N1 UART deserialiser, message framer/validator and hold-until-acked output register.
// Define MSG_CHECKSUM_EN to expect and verify a trailing XOR checksum byte on every frame.
module pong_msg_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 40
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       UART_RXD,
    input  logic       message_acked,
    output logic       new_message_received,
    output logic       ball_message_rx,
    output logic       miss_message_rx,
    output logic       new_game_message_rx,
    output logic       new_game_ack_message_rx,
    output logic [8:0] ball_y_rx,
    output logic [3:0] velocity_x_rx,
    output logic [3:0] velocity_y_rx,
    output logic       sign_y_rx,
    output logic [4:0] my_score_rx,
    output logic [4:0] your_score_rx,
    output logic       you_should_serve_rx,
    output logic       you_serve_first_rx,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W   = $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TO_CYC - 1);

    // ---------------- input synchroniser ----------------
    logic rx_s1, rx_s2, rx_prev;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= UART_RXD;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // ---------------- byte receiver ----------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t        rx_state, rx_state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_byte;
    logic             bit_tick, byte_valid, stop_err;

    assign bit_tick = (rx_state == RX_START) ? (bit_cnt == HALF_M1) : (bit_cnt == FULL_M1);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            if (rx_state == RX_IDLE || bit_tick)
                bit_cnt <= '0;
            else
                bit_cnt <= bit_cnt + CNT_W'(1);
            if (rx_state == RX_START)
                bit_idx <= '0;
            else if (rx_state == RX_DATA && bit_tick)
                bit_idx <= bit_idx + 3'd1;
        end
    end

    // Shift register carries data only, so it is left out of reset.
    always_ff @(posedge CLOCK_50) begin
        if (rx_state == RX_DATA && bit_tick)
            rx_byte <= {rx_s2, rx_byte[7:1]};
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s2) rx_state_nxt = RX_START;
            RX_START: if (bit_tick) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx == 3'd7) rx_state_nxt = RX_STOP;
            RX_STOP:  if (bit_tick) rx_state_nxt = RX_IDLE;
            default:  rx_state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        if (rx_state == RX_STOP && bit_tick) begin
            byte_valid = rx_s2;
            stop_err   = !rx_s2;
        end
    end

    // ---------------- frame parser ----------------
`ifdef MSG_CHECKSUM_EN
    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_CHECK} p_state_t;
`else
    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD} p_state_t;
`endif
    p_state_t        p_state, p_state_nxt;
    logic [2:0]      msg_type, type_nxt;
    logic [1:0]      plen, pidx, plen_in;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      pb0, pb1, b1_n, b2_n;
    logic [1:0]      pb2, b3_n;
    logic            hdr_ok, last_payload, store, timeout_hit, commit, frame_err_evt;
`ifdef MSG_CHECKSUM_EN
    logic [7:0]      xor_acc;
    logic            cs_err;
`endif

    // Header low bits 1..4 map to payload lengths 3..0.
    assign plen_in      = 2'(3'd4 - rx_byte[2:0]);
    assign hdr_ok       = (rx_byte[7:3] == 5'b10100) && (rx_byte[2:0] >= 3'd1) && (rx_byte[2:0] <= 3'd4);
    assign last_payload = (pidx == plen - 2'd1);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            p_state  <= P_HUNT;
            msg_type <= '0;
            plen     <= '0;
            pidx     <= '0;
            to_cnt   <= '0;
        end else begin
            p_state <= p_state_nxt;
            if (p_state == P_HUNT || byte_valid)
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + TO_W'(1);
            if (byte_valid && p_state == P_HUNT && hdr_ok) begin
                msg_type <= rx_byte[2:0];
                plen     <= plen_in;
                pidx     <= '0;
            end else if (store) begin
                pidx <= pidx + 2'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (store) begin
            pb0 <= b1_n;
            pb1 <= b2_n;
            pb2 <= b3_n;
        end
`ifdef MSG_CHECKSUM_EN
        if (byte_valid && p_state == P_HUNT)
            xor_acc <= rx_byte;
        else if (store)
            xor_acc <= xor_acc ^ rx_byte;
`endif
    end

    always_comb begin
        p_state_nxt = p_state;
        if (stop_err || timeout_hit) begin
            p_state_nxt = P_HUNT;
        end else if (byte_valid) begin
            case (p_state)
`ifdef MSG_CHECKSUM_EN
                P_HUNT:    if (hdr_ok) p_state_nxt = (plen_in == 2'd0) ? P_CHECK : P_PAYLOAD;
                P_PAYLOAD: if (last_payload) p_state_nxt = P_CHECK;
                P_CHECK:   p_state_nxt = P_HUNT;
`else
                P_HUNT:    if (hdr_ok && plen_in != 2'd0) p_state_nxt = P_PAYLOAD;
                P_PAYLOAD: if (last_payload) p_state_nxt = P_HUNT;
`endif
                default:   p_state_nxt = P_HUNT;
            endcase
        end
    end

    // Shadow buffer view including the byte arriving this cycle, so a frame can commit on its last payload byte.
    always_comb begin
        store       = byte_valid && (p_state == P_PAYLOAD);
        timeout_hit = (p_state != P_HUNT) && !byte_valid && (to_cnt == TO_M1);
        b1_n        = (store && pidx == 2'd0) ? rx_byte : pb0;
        b2_n        = (store && pidx == 2'd1) ? rx_byte : pb1;
        b3_n        = (store && pidx == 2'd2) ? rx_byte[1:0] : pb2;
        type_nxt    = (p_state == P_HUNT) ? rx_byte[2:0] : msg_type;
`ifdef MSG_CHECKSUM_EN
        commit        = byte_valid && (p_state == P_CHECK) && (rx_byte == xor_acc);
        cs_err        = byte_valid && (p_state == P_CHECK) && (rx_byte != xor_acc);
        frame_err_evt = stop_err || timeout_hit || cs_err;
`else
        commit        = byte_valid && ((p_state == P_HUNT && rx_byte == 8'hA4) ||
                                       (p_state == P_PAYLOAD && last_payload));
        frame_err_evt = stop_err || timeout_hit;
`endif
    end

    // ---------------- hold register / handshake ----------------
    logic ack_eff;
    assign ack_eff = message_acked && new_message_received;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            new_message_received    <= 1'b0;
            ball_message_rx         <= 1'b0;
            miss_message_rx         <= 1'b0;
            new_game_message_rx     <= 1'b0;
            new_game_ack_message_rx <= 1'b0;
            ball_y_rx               <= '0;
            velocity_x_rx           <= '0;
            velocity_y_rx           <= '0;
            sign_y_rx               <= 1'b0;
            my_score_rx             <= '0;
            your_score_rx           <= '0;
            you_should_serve_rx     <= 1'b0;
            you_serve_first_rx      <= 1'b0;
            frame_error             <= 1'b0;
            overrun                 <= 1'b0;
        end else begin
            frame_error <= frame_err_evt;
            overrun     <= commit && new_message_received && !ack_eff;
            if (commit && (!new_message_received || ack_eff)) begin
                new_message_received    <= 1'b1;
                ball_message_rx         <= (type_nxt == 3'd1);
                miss_message_rx         <= (type_nxt == 3'd2);
                new_game_message_rx     <= (type_nxt == 3'd3);
                new_game_ack_message_rx <= (type_nxt == 3'd4);
                case (type_nxt)
                    3'd1: begin
                        ball_y_rx     <= {b3_n[0], b1_n};
                        velocity_x_rx <= b2_n[7:4];
                        velocity_y_rx <= b2_n[3:0];
                        sign_y_rx     <= b3_n[1];
                    end
                    3'd2: begin
                        // Sender's view is mirrored: its "my" score is our "your" score.
                        my_score_rx         <= b2_n[4:0];
                        your_score_rx       <= b1_n[4:0];
                        you_should_serve_rx <= b2_n[5];
                    end
                    3'd3: you_serve_first_rx <= b1_n[0];
                    default: ;
                endcase
            end else if (ack_eff) begin
                new_message_received    <= 1'b0;
                ball_message_rx         <= 1'b0;
                miss_message_rx         <= 1'b0;
                new_game_message_rx     <= 1'b0;
                new_game_ack_message_rx <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pong_msg_receiver.sv
// Directed, table-driven bench for pong_msg_receiver with a short bit period; follows MSG_CHECKSUM_EN like the DUT.
module tb_pong_msg_receiver;

    localparam int CPB = 16;
    localparam int TOB = 40;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       UART_RXD = 1'b1;
    logic       message_acked = 1'b0;
    logic       new_message_received;
    logic       ball_message_rx, miss_message_rx, new_game_message_rx, new_game_ack_message_rx;
    logic [8:0] ball_y_rx;
    logic [3:0] velocity_x_rx, velocity_y_rx;
    logic       sign_y_rx;
    logic [4:0] my_score_rx, your_score_rx;
    logic       you_should_serve_rx, you_serve_first_rx;
    logic       frame_error, overrun;

    int n_cmp = 0;
    int n_fail = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    pong_msg_receiver #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .UART_RXD               (UART_RXD),
        .message_acked          (message_acked),
        .new_message_received   (new_message_received),
        .ball_message_rx        (ball_message_rx),
        .miss_message_rx        (miss_message_rx),
        .new_game_message_rx    (new_game_message_rx),
        .new_game_ack_message_rx(new_game_ack_message_rx),
        .ball_y_rx              (ball_y_rx),
        .velocity_x_rx          (velocity_x_rx),
        .velocity_y_rx          (velocity_y_rx),
        .sign_y_rx              (sign_y_rx),
        .my_score_rx            (my_score_rx),
        .your_score_rx          (your_score_rx),
        .you_should_serve_rx    (you_should_serve_rx),
        .you_serve_first_rx     (you_serve_first_rx),
        .frame_error            (frame_error),
        .overrun                (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (frame_error === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    typedef struct {
        logic [31:0] bytes;   // header in [7:0], payload following, checksum not included
        int          n;
        logic        junk;    // send 00 55 ahead of the frame
        logic [3:0]  onehot;  // {ball, miss, new_game, ack}
        int          ball_y, vx, vy, sy, my, your, serve, first;
    } vec_t;

    vec_t vecs[4];
    vec_t ball2;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tx_byte(input logic [7:0] b, input logic stop_bit);
        UART_RXD = 1'b0;
        wait_clk(CPB);
        for (int i = 0; i < 8; i++) begin
            UART_RXD = b[i];
            wait_clk(CPB);
        end
        UART_RXD = stop_bit;
        wait_clk(CPB);
        UART_RXD = 1'b1;
        if (!stop_bit) wait_clk(CPB);
    endtask

    task automatic send_frame(input vec_t v);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        if (v.junk) begin
            tx_byte(8'h00, 1'b1);
            tx_byte(8'h55, 1'b1);
        end
        for (int i = 0; i < v.n; i++) begin
            b = v.bytes[8*i +: 8];
            cs = cs ^ b;
            tx_byte(b, 1'b1);
        end
`ifdef MSG_CHECKSUM_EN
        tx_byte(cs, 1'b1);
`endif
        wait_clk(3);
    endtask

    task automatic check_vec(input vec_t v, input string tag);
        chk({tag, "_nmr"}, int'(new_message_received), 1);
        chk({tag, "_type"}, int'({ball_message_rx, miss_message_rx, new_game_message_rx, new_game_ack_message_rx}),
            int'(v.onehot));
        case (v.onehot)
            4'b1000: begin
                chk({tag, "_ball_y"}, int'(ball_y_rx), v.ball_y);
                chk({tag, "_vx"}, int'(velocity_x_rx), v.vx);
                chk({tag, "_vy"}, int'(velocity_y_rx), v.vy);
                chk({tag, "_sign_y"}, int'(sign_y_rx), v.sy);
            end
            4'b0100: begin
                chk({tag, "_my_score"}, int'(my_score_rx), v.my);
                chk({tag, "_your_score"}, int'(your_score_rx), v.your);
                chk({tag, "_serve"}, int'(you_should_serve_rx), v.serve);
            end
            4'b0010: chk({tag, "_serve_first"}, int'(you_serve_first_rx), v.first);
            default: ;
        endcase
    endtask

    task automatic do_ack(input string tag);
        message_acked = 1'b1;
        wait_clk(1);
        message_acked = 1'b0;
        chk({tag, "_nmr_cleared"}, int'(new_message_received), 0);
        chk({tag, "_type_cleared"},
            int'({ball_message_rx, miss_message_rx, new_game_message_rx, new_game_ack_message_rx}), 0);
        wait_clk(1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_nmr"}, int'(new_message_received), 0);
        chk({tag, "_types"}, int'({ball_message_rx, miss_message_rx, new_game_message_rx, new_game_ack_message_rx}), 0);
        chk({tag, "_ball_y"}, int'(ball_y_rx), 0);
        chk({tag, "_vel"}, int'({velocity_x_rx, velocity_y_rx, sign_y_rx}), 0);
        chk({tag, "_scores"}, int'({my_score_rx, your_score_rx}), 0);
        chk({tag, "_serve"}, int'({you_should_serve_rx, you_serve_first_rx}), 0);
        chk({tag, "_err"}, int'({frame_error, overrun}), 0);
    endtask

    initial begin
        int fe0;
        int ov0;

        //            bytes          n  junk onehot   y   vx vy sy my your serve first
        vecs[0] = '{32'h03322CA1, 4, 1'b0, 4'b1000, 300, 3, 2, 1, 0, 0,   0,    0};
        vecs[1] = '{32'h002503A2, 3, 1'b1, 4'b0100, 0,   0, 0, 0, 5, 3,   1,    0};
        vecs[2] = '{32'h000001A3, 2, 1'b0, 4'b0010, 0,   0, 0, 0, 0, 0,   0,    1};
        vecs[3] = '{32'h000000A4, 1, 1'b0, 4'b0001, 0,   0, 0, 0, 0, 0,   0,    0};
        ball2   = '{32'h004510A1, 4, 1'b0, 4'b1000, 16,  4, 5, 0, 0, 0,   0,    0};

        wait_clk(3);
        check_all_zero("reset");
        reset = 1'b0;
        wait_clk(4);

        for (int i = 0; i < 4; i++) begin
            send_frame(vecs[i]);
            check_vec(vecs[i], $sformatf("vec%0d", i));
            wait_clk(100);
            check_vec(vecs[i], $sformatf("vec%0d_hold", i));
            do_ack($sformatf("vec%0d", i));
            if (i == 0) chk("ball_y_kept_after_ack", int'(ball_y_rx), 300);
        end
        chk("no_errors_in_table", fe_cnt, 0);
        chk("no_overrun_in_table", ov_cnt, 0);

        message_acked = 1'b1;
        wait_clk(2);
        message_acked = 1'b0;
        chk("ack_while_empty", int'(new_message_received), 0);

`ifdef MSG_CHECKSUM_EN
        fe0 = fe_cnt;
        tx_byte(8'hA3, 1'b1);
        tx_byte(8'h01, 1'b1);
        tx_byte(8'h00, 1'b1);
        wait_clk(3);
        chk("cksum_frame_error", fe_cnt, fe0 + 1);
        chk("cksum_no_msg", int'(new_message_received), 0);
`endif

        fe0 = fe_cnt;
        tx_byte(8'hA1, 1'b1);
        tx_byte(8'h2C, 1'b0);
        wait_clk(3);
        chk("stop_frame_error", fe_cnt, fe0 + 1);
        chk("stop_no_msg", int'(new_message_received), 0);
        send_frame(vecs[1]);
        check_vec(vecs[1], "after_stop_err");
        do_ack("after_stop_err");

        ov0 = ov_cnt;
        send_frame(vecs[0]);
        send_frame(ball2);
        chk("overrun_pulse", ov_cnt, ov0 + 1);
        check_vec(vecs[0], "overrun_held");
        do_ack("overrun");
        send_frame(ball2);
        check_vec(ball2, "after_overrun");
        do_ack("after_overrun");
        chk("overrun_once", ov_cnt, ov0 + 1);

        fe0 = fe_cnt;
        tx_byte(8'hA1, 1'b1);
        tx_byte(8'h2C, 1'b1);
        wait_clk(38 * CPB);
        chk("timeout_not_early", fe_cnt, fe0);
        wait_clk(3 * CPB);
        chk("timeout_frame_error", fe_cnt, fe0 + 1);
        chk("timeout_no_msg", int'(new_message_received), 0);
        send_frame(vecs[2]);
        check_vec(vecs[2], "after_timeout");
        do_ack("after_timeout");

        send_frame(vecs[0]);
        chk("held_before_reset", int'(new_message_received), 1);
        tx_byte(8'hA1, 1'b1);
        UART_RXD = 1'b0;
        wait_clk(3 * CPB);
        #2;
        reset = 1'b1;
        UART_RXD = 1'b1;
        #1;
        check_all_zero("midframe_reset");
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2 * CPB);
        send_frame(vecs[3]);
        check_vec(vecs[3], "after_reset");
        do_ack("after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
